uart_frame_loader: RTL and testbench
====================================

UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 1024: pixel bytes per frame.
REQ-002 SHALL have parameter ADDR_W, default 10: pixel address width, with 2**ADDR_W >= NUM_PIXELS.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hAA: frame start marker.
REQ-004 SHALL have parameter TIMEOUT, default 50000: maximum number of clk cycles allowed between bytes inside a frame.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-007 SHALL have port i_DV, input, 1 bit: one-cycle byte-valid strobe from the UART receiver.
REQ-008 SHALL have port pixel_in, input, 8 bits: received byte, valid when i_DV=1.
REQ-009 SHALL have port wr_en, output, 1 bit: frame-buffer write strobe.
REQ-010 SHALL have port wr_addr, output, ADDR_W+1 bits: {bank, pixel index}.
REQ-011 SHALL have port wr_data, output, 8 bits: pixel byte to write.
REQ-012 SHALL have port disp_bank, output, 1 bit: bank the display reads; the loader writes bank ~disp_bank.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame is committed.
REQ-014 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is rejected.

Function
REQ-015 SHALL implement states IDLE, LOAD, CHECK.
REQ-016 IDLE: on i_DV with pixel_in==SYNC_BYTE, SHALL clear idx, checksum and gap counter, then go to LOAD; all other bytes SHALL be ignored.
REQ-017 LOAD: on each i_DV, SHALL register wr_en=1, wr_addr={~disp_bank, idx}, wr_data=pixel_in, with one-cycle latency from i_DV.
REQ-018 LOAD: on each i_DV, SHALL XOR pixel_in into the checksum and increment idx; after the byte with idx==NUM_PIXELS-1, SHALL go to CHECK.
REQ-019 In LOAD, a byte equal to SYNC_BYTE SHALL be treated as pixel data, not as a resync.
REQ-020 CHECK: on i_DV, if pixel_in equals the checksum, SHALL toggle disp_bank and pulse frame_done the next cycle.
REQ-021 CHECK: on i_DV, if pixel_in differs from the checksum, SHALL pulse frame_err and leave disp_bank unchanged.
REQ-022 After either CHECK outcome, SHALL return to IDLE.
REQ-023 Gap counter SHALL clear on every i_DV and increment every other cycle in LOAD/CHECK.
REQ-024 On reaching TIMEOUT, SHALL pulse frame_err, return to IDLE, and leave disp_bank unchanged.
REQ-025 If i_DV and timeout occur in the same cycle, the byte SHALL win and the counter SHALL clear.
REQ-026 wr_en, frame_done and frame_err SHALL each be high for at most one cycle per event; wr_en SHALL never assert outside LOAD.
REQ-027 idx SHALL never exceed NUM_PIXELS-1 and SHALL not wrap.
REQ-028 The gap counter SHALL be $clog2(TIMEOUT+1) bits wide and saturate at TIMEOUT.

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE and set wr_en, wr_addr, wr_data, disp_bank, frame_done, frame_err, idx, checksum and gap counter to 0.
REQ-030 Reset mid-frame SHALL discard the partial frame without pulsing frame_err.
REQ-031 Release of rst_n SHALL be used synchronously to clk by the instantiating top.

Structure
REQ-032 State encodings and SYNC_BYTE default SHALL live in shared package pantalla_pkg.
REQ-033 The gap counter SHALL be a sub-module, byte_gap_timer (ports clk, rst_n, clr, en, expired).
REQ-034 The loader SHALL contain no RAM; the frame buffer is external.

Verification
REQ-035 NUM_PIXELS=4; bytes AA,01,02,03,04,04 -> writes to addrs {1,0..3} with data 01..04, one frame_done, disp_bank 0->1.
REQ-036 Same frame with checksum byte 05 -> frame_err pulse, disp_bank stays 0, no frame_done.
REQ-037 Bytes 55,00 before AA -> no writes until AA, then a normal frame.
REQ-038 AA,01,02 then idle TIMEOUT cycles -> frame_err at the TIMEOUT-th idle cycle, state IDLE, and the next AA frame loads from idx 0.
REQ-039 rst_n pulsed low after the 2nd pixel -> all outputs 0 immediately, no frame_err; the next full frame commits to bank 1.
REQ-040 Two back-to-back good frames -> writes go to bank 1 then bank 0, disp_bank 0->1->0, two frame_done pulses.

Source files
------------

// File: rtl/pantalla_pkg.sv
// Shared constants for the display frame path: loader FSM encodings and the
// default frame start marker.
package pantalla_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;

endpackage

// File: rtl/byte_gap_timer.sv
// Counts idle clk cycles between received bytes. It flags the cycle whose
// increment would reach TIMEOUT, then saturates until cleared.
module byte_gap_timer #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX_CNT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A byte in the same cycle always beats the timeout.
  assign expired = en && !clr && (cnt == LAST_CNT);

endmodule

// File: rtl/uart_frame_loader.sv
// Loads one sync-prefixed, XOR-checksummed frame of pixel bytes from a UART
// into the back bank of an external double-buffered frame store.
module uart_frame_loader
  import pantalla_pkg::*;
#(
  parameter int         NUM_PIXELS = 1024,
  parameter int         ADDR_W     = 10,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT    = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_DV,
  input  logic [7:0]        pixel_in,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [7:0]        wr_data,
  output logic              disp_bank,
  output logic              frame_done,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        checksum;
  logic              gap_en;
  logic              gap_expired;

  assign gap_en = (state != ST_IDLE);

  byte_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (i_DV),
    .en      (gap_en),
    .expired (gap_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      checksum   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      disp_bank  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_DV && (pixel_in == SYNC_BYTE)) begin
            idx      <= '0;
            checksum <= '0;
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Every byte here is pixel data, including ones equal to SYNC_BYTE.
          if (i_DV) begin
            wr_en    <= 1'b1;
            wr_addr  <= {~disp_bank, idx};
            wr_data  <= pixel_in;
            checksum <= checksum ^ pixel_in;
            if (idx == LAST_IDX) begin
              state <= ST_CHECK;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (gap_expired) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (i_DV) begin
            if (pixel_in == checksum) begin
              disp_bank  <= ~disp_bank;
              frame_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= ST_IDLE;
          end else if (gap_expired) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader with a 4-pixel frame and a short byte timeout.
module tb_uart_frame_loader;
  import pantalla_pkg::*;

  localparam int NP = 4;
  localparam int AW = 2;
  localparam int TO = 20;
  localparam int W  = AW + 1 + 8;
  localparam logic [1:0] EV_NONE = 2'b00;
  localparam logic [1:0] EV_DONE = 2'b10;
  localparam logic [1:0] EV_ERR  = 2'b01;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_DV = 1'b0;
  logic [7:0]    pixel_in = 8'h00;
  logic          wr_en;
  logic [AW:0]   wr_addr;
  logic [7:0]    wr_data;
  logic          disp_bank;
  logic          frame_done;
  logic          frame_err;

  uart_frame_loader #(
    .NUM_PIXELS (NP),
    .ADDR_W     (AW),
    .SYNC_BYTE  (8'hAA),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_DV       (i_DV),
    .pixel_in   (pixel_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .disp_bank  (disp_bank),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic        wr;
    logic [AW:0] addr;
    logic [7:0]  data;
    logic [1:0]  ev;
    logic        bank;
  } vec_t;

  vec_t       tbl[$];
  logic [W-1:0] exp_q[$];
  logic [1:0]   ev_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // scoreboard: every write and every done/err pulse must match the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h required=none", {wr_addr, wr_data});
        end else begin
          check("write", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
        end
      end
      if (frame_done || frame_err) begin
        if (ev_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event actual=%0b required=none", {frame_done, frame_err});
        end else begin
          check("event", 32'({frame_done, frame_err}), 32'(ev_q.pop_front()));
        end
      end
    end
  end

  // driver: called at a negedge, returns at the negedge after the strobe
  task automatic send_byte(input logic [7:0] b, input int pre_gap);
    repeat (pre_gap) @(negedge clk);
    i_DV     = 1'b1;
    pixel_in = b;
    @(negedge clk);
    i_DV     = 1'b0;
    pixel_in = 8'($urandom_range(0, 255));
  endtask

  function automatic void add(input logic [7:0] b, input logic wr, input logic [AW:0] addr,
                              input logic [7:0] data, input logic [1:0] ev, input logic bank);
    vec_t v;
    v.b = b; v.wr = wr; v.addr = addr; v.data = data; v.ev = ev; v.bank = bank;
    tbl.push_back(v);
  endfunction

  // sync byte, four pixels into bank wb, then the checksum byte
  function automatic void add_frame(input logic [31:0] pix, input logic [7:0] chk, input logic wb,
                                    input logic [1:0] ev, input logic bank_before,
                                    input logic bank_after);
    logic [7:0] p;
    add(8'hAA, 1'b0, '0, 8'h00, EV_NONE, bank_before);
    for (int i = 0; i < NP; i++) begin
      p = pix[31-8*i -: 8];
      add(p, 1'b1, {wb, AW'(i)}, p, EV_NONE, bank_before);
    end
    add(chk, 1'b0, '0, 8'h00, ev, bank_after);
  endfunction

  task automatic apply_table();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) exp_q.push_back({tbl[i].addr, tbl[i].data});
      if (tbl[i].ev != EV_NONE) ev_q.push_back(tbl[i].ev);
      send_byte(tbl[i].b, $urandom_range(0, 3));
      check("disp_bank", 32'(disp_bank), 32'(tbl[i].bank));
    end
    tbl.delete();
  endtask

  task automatic summary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  initial begin
    #200000;
    checks++;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    summary();
    $finish;
  end

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({wr_en, wr_addr, wr_data, disp_bank, frame_done, frame_err}), 32'h0);
    check("reset_state", 32'(dut.state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // bad checksum, junk before sync, back-to-back good frames, sync byte as data
    add_frame(32'h01020304, 8'h05, 1'b1, EV_ERR,  1'b0, 1'b0);
    add(8'h55, 1'b0, '0, 8'h00, EV_NONE, 1'b0);
    add(8'h00, 1'b0, '0, 8'h00, EV_NONE, 1'b0);
    add_frame(32'h01020304, 8'h04, 1'b1, EV_DONE, 1'b0, 1'b1);
    add_frame(32'h10203040, 8'h40, 1'b0, EV_DONE, 1'b1, 1'b0);
    add_frame(32'h01020304, 8'h04, 1'b1, EV_DONE, 1'b0, 1'b1);
    add_frame(32'hAA01AA02, 8'h03, 1'b0, EV_DONE, 1'b1, 1'b0);
    apply_table();

    // timeout after two pixels
    exp_q.push_back({1'b1, 2'd0, 8'h01});
    exp_q.push_back({1'b1, 2'd1, 8'h02});
    ev_q.push_back(EV_ERR);
    send_byte(8'hAA, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    seen = 0;
    for (int i = 1; i <= TO + 5; i++) begin
      @(negedge clk);
      if (frame_err) begin
        seen = i;
        break;
      end
    end
    check("timeout_cycle", 32'(seen), 32'(TO));
    check("timeout_state", 32'(dut.state), 32'(ST_IDLE));
    check("timeout_bank", 32'(disp_bank), 32'h0);
    add_frame(32'h05060708, 8'h0C, 1'b1, EV_DONE, 1'b0, 1'b1);
    apply_table();

    // reset in the middle of a frame while bank 1 is displayed
    exp_q.push_back({1'b0, 2'd0, 8'h01});
    exp_q.push_back({1'b0, 2'd1, 8'h02});
    send_byte(8'hAA, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs", 32'({wr_en, wr_addr, wr_data, disp_bank, frame_done, frame_err}), 32'h0);
    check("midreset_state", 32'(dut.state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    add_frame(32'h0A0B0C0D, 8'h00, 1'b1, EV_DONE, 1'b0, 1'b1);
    apply_table();

    // a byte landing exactly on the timeout cycle keeps the frame alive
    exp_q.push_back({1'b0, 2'd0, 8'h11});
    exp_q.push_back({1'b0, 2'd1, 8'h33});
    exp_q.push_back({1'b0, 2'd2, 8'h44});
    exp_q.push_back({1'b0, 2'd3, 8'h55});
    ev_q.push_back(EV_DONE);
    send_byte(8'hAA, 0);
    send_byte(8'h11, 0);
    send_byte(8'h33, TO - 1);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    send_byte(8'h33, 0);
    check("race_bank", 32'(disp_bank), 32'h0);

    repeat (5) @(negedge clk);
    check("write_queue_empty", 32'(exp_q.size()), 32'h0);
    check("event_queue_empty", 32'(ev_q.size()), 32'h0);
    summary();
    $finish;
  end

endmodule
